vga_grid_capture: RTL and testbench

VGA_GRID_CAPTURE -- requirements
Module: vga_grid_capture

---
 rtl/vga_grid_capture.sv | 203 ++++++++++++++++++++
 tb/tb_vga_grid_capture.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_grid_capture.sv
// vga_grid_capture: locks onto a VGA timing stream and captures a 10x22 cell
// playfield by sampling the pixel colour at the centre of every cell. A frame
// is published on grid_o only when it was captured entirely while locked.
module vga_grid_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int GRID_X0  = 220,
  parameter int GRID_Y0  = 20,
  parameter int CELL     = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hsync_i,
  input  logic                   vsync_i,
  input  logic [2:0]             color_i,
  output logic [21:0][9:0][2:0]  grid_o,
  output logic                   frame_valid_o,
  output logic                   locked_o,
  output logic                   sync_err_o,
  output logic [7:0]             frame_cnt_o
);

  localparam int COLS    = 10;
  localparam int ROWS    = 22;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_OFS   = H_SYNC + H_BP;
  localparam int V_OFS   = V_SYNC + V_BP;
  localparam int CW      = 16;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

  state_t                  state;
  logic                    hs, vs, hs_d, vs_d;
  logic [2:0]              col;
  logic                    hs_fall, vs_fall;
  logic [CW-1:0]           hcnt_q, vcnt_q, hcount, vcount;
  logic [CW-1:0]           edge_cnt;
  logic                    line_ok, line_err;
  logic [CW:0]             px_ext, py_ext;
  logic                    px_act, py_act;
  logic                    col_hit, row_hit;
  logic [3:0]              col_idx;
  logic [4:0]              row_idx;
  logic [21:0][9:0][2:0]   shadow;

  // Register the raw inputs once and keep one extra sample of the syncs so
  // falling edges can be seen as "was 1, now 0".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs   <= 1'b1;
      vs   <= 1'b1;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      col  <= '0;
    end else begin
      hs   <= hsync_i;
      vs   <= vsync_i;
      hs_d <= hs;
      vs_d <= vs;
      col  <= color_i;
    end
  end

  assign hs_fall = hs_d & ~hs;
  assign vs_fall = vs_d & ~vs;

  // A line is bad if an hs edge arrives at the wrong spacing, or if the
  // counter reaches a full line length without seeing one.
  assign line_err = hs_fall ? (hcnt_q != H_LAST) : (hcnt_q == H_LAST);

  // Current-cycle pixel and line positions; both saturate instead of wrapping
  // so a missing sync cannot alias back into the active area.
  always_comb begin
    hcount = hcnt_q;
    vcount = vcnt_q;
    if (hs_fall) begin
      hcount = '0;
    end else if (hcnt_q != CNT_MAX) begin
      hcount = hcnt_q + CW'(1);
    end
    if (vs_fall) begin
      vcount = '0;
    end else if (hs_fall && (vcnt_q != CNT_MAX)) begin
      vcount = vcnt_q + CW'(1);
    end
  end

  assign px_ext = {1'b0, hcount} - (CW+1)'(H_OFS);
  assign py_ext = {1'b0, vcount} - (CW+1)'(V_OFS);
  assign px_act = ~px_ext[CW] && (px_ext[CW-1:0] < CW'(H_ACTIVE));
  assign py_act = ~py_ext[CW] && (py_ext[CW-1:0] < CW'(V_ACTIVE));

  // Decode whether the current pixel sits at the centre of a cell column/row.
  always_comb begin
    col_hit = 1'b0;
    col_idx = '0;
    row_hit = 1'b0;
    row_idx = '0;
    for (int c = 0; c < COLS; c++) begin
      if (px_ext[CW-1:0] == CW'(GRID_X0 + c*CELL + CELL/2)) begin
        col_hit = 1'b1;
        col_idx = 4'(c);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (py_ext[CW-1:0] == CW'(GRID_Y0 + r*CELL + CELL/2)) begin
        row_hit = 1'b1;
        row_idx = 5'(r);
      end
    end
  end

  // Line/frame counters plus the per-frame line count and spacing health
  // used to decide whether a frame is good enough to lock onto.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      edge_cnt <= '0;
      line_ok  <= 1'b1;
    end else begin
      hcnt_q <= hcount;
      vcnt_q <= vcount;
      if (vs_fall) begin
        edge_cnt <= hs_fall ? CW'(1) : '0;
        line_ok  <= 1'b1;
      end else begin
        if (hs_fall && (edge_cnt != CNT_MAX)) begin
          edge_cnt <= edge_cnt + CW'(1);
        end
        if (line_err) begin
          line_ok <= 1'b0;
        end
      end
    end
  end

  // Sample each cell centre into the shadow buffer; it is only ever exposed
  // through a publish, so partial frames never reach grid_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (px_act && py_act && col_hit && row_hit) begin
      shadow[row_idx][col_idx] <= col;
    end
  end

  // Lock state machine with registered outputs; publishing copies the shadow
  // on a clean vs edge while locked, errors drop straight back to HUNT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      grid_o        <= '0;
      frame_valid_o <= 1'b0;
      locked_o      <= 1'b0;
      sync_err_o    <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      frame_valid_o <= 1'b0;
      sync_err_o    <= 1'b0;
      case (state)
        HUNT: begin
          if (vs_fall) begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          if (vs_fall && (edge_cnt == V_TOTAL_C) && line_ok && !line_err) begin
            state    <= LOCKED;
            locked_o <= 1'b1;
          end
        end
        LOCKED: begin
          if (line_err || (vs_fall && (edge_cnt != V_TOTAL_C))) begin
            state      <= HUNT;
            locked_o   <= 1'b0;
            sync_err_o <= 1'b1;
          end else if (vs_fall) begin
            grid_o        <= shadow;
            frame_valid_o <= 1'b1;
            frame_cnt_o   <= frame_cnt_o + 8'd1;
          end
        end
        default: begin
          state    <= HUNT;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_grid_capture.sv
// tb_vga_grid_capture: drives whole VGA frames with a shrunken timing
// (12 clocks x 24 lines, one-pixel cells) and scoreboards every publish.
module tb_vga_grid_capture;

  localparam int H_ACTIVE = 11;
  localparam int H_FP     = 0;
  localparam int H_SYNC   = 1;
  localparam int H_BP     = 0;
  localparam int V_ACTIVE = 23;
  localparam int V_FP     = 0;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 0;
  localparam int GRID_X0  = 1;
  localparam int GRID_Y0  = 1;
  localparam int CELL     = 1;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [21:0][9:0][2:0] grid_t;
  typedef struct packed {
    logic [7:0] cnt;
    grid_t      grid;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        hsync_i;
  logic        vsync_i;
  logic [2:0]  color_i;
  grid_t       grid_o;
  logic        frame_valid_o;
  logic        locked_o;
  logic        sync_err_o;
  logic [7:0]  frame_cnt_o;

  int          compared     = 0;
  int          mismatched   = 0;
  int          pub_seen     = 0;
  int          err_seen     = 0;
  int          pub_expected = 0;
  int          err_expected = 0;
  logic [7:0]  exp_cnt      = 8'd0;
  exp_t        exp_q[$];
  grid_t       stim_grid;
  grid_t       last_grid;
  grid_t       last_pushed;
  grid_t       red_grid;
  grid_t       blue_grid;

  vga_grid_capture #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .GRID_X0(GRID_X0), .GRID_Y0(GRID_Y0), .CELL(CELL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .color_i      (color_i),
    .grid_o       (grid_o),
    .frame_valid_o(frame_valid_o),
    .locked_o     (locked_o),
    .sync_err_o   (sync_err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  // Free-running pixel clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [1023:0] act,
                              input logic [1023:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic grid_t pattern(input int seed);
    grid_t g;
    for (int r = 0; r < 22; r++) begin
      for (int c = 0; c < 10; c++) begin
        g[r][c] = 3'((r*5 + c*3 + seed) % 8);
      end
    end
    return g;
  endfunction

  // Drives one frame of n_lines lines starting with the vs edge; short_line
  // selects one line that is a clock short. When publish is set, the frame
  // before this one is expected to appear on grid_o just after this vs edge.
  task automatic apply_stimulus(input bit publish, input int n_lines,
                                input int short_line);
    int len;
    int px;
    int py;
    if (publish) begin
      exp_cnt++;
      last_pushed = last_grid;
      exp_q.push_back({exp_cnt, last_grid});
      pub_expected++;
    end
    for (int v = 0; v < n_lines; v++) begin
      len = (v == short_line) ? H_TOTAL - 1 : H_TOTAL;
      for (int h = 0; h < len; h++) begin
        px = h - (H_SYNC + H_BP);
        py = v - (V_SYNC + V_BP);
        @(posedge clk);
        #1;
        hsync_i = (h < H_SYNC) ? 1'b0 : 1'b1;
        vsync_i = (v < V_SYNC) ? 1'b0 : 1'b1;
        color_i = 3'b111;
        if (px >= GRID_X0 && px < GRID_X0 + 10 && py >= GRID_Y0 && py < GRID_Y0 + 22)
          color_i = stim_grid[py - GRID_Y0][px - GRID_X0];
      end
    end
    last_grid = stim_grid;
  endtask

  // Monitor: pops the scoreboard on every publish and tallies error pulses.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (frame_valid_o || sync_err_o)
        check_output("valid_err_exclusive", 1024'(frame_valid_o & sync_err_o), 1024'(0));
      if (sync_err_o) err_seen++;
      if (frame_valid_o) begin
        pub_seen++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL publish_unexpected: got frame_valid 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          check_output("publish_grid", 1024'(grid_o), 1024'(e.grid));
          check_output("publish_cnt", 1024'(frame_cnt_o), 1024'(e.cnt));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_grid"}, 1024'(grid_o), 1024'(0));
    check_output({tag, "_valid"}, 1024'(frame_valid_o), 1024'(0));
    check_output({tag, "_locked"}, 1024'(locked_o), 1024'(0));
    check_output({tag, "_err"}, 1024'(sync_err_o), 1024'(0));
    check_output({tag, "_cnt"}, 1024'(frame_cnt_o), 1024'(0));
  endtask

  // Directed sequence: lock and publish, single-cell frame, line error,
  // short frame, counter wrap, then mid-frame reset and re-lock.
  initial begin
    rst_n   = 1'b0;
    hsync_i = 1'b1;
    vsync_i = 1'b1;
    color_i = 3'b000;
    last_grid = '0;
    last_pushed = '0;
    for (int r = 0; r < 22; r++) begin
      for (int c = 0; c < 10; c++) begin
        red_grid[r][c]  = 3'b100;
        blue_grid[r][c] = 3'b000;
      end
    end
    blue_grid[21][9] = 3'b001;

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    stim_grid = red_grid;
    apply_stimulus(1'b0, V_TOTAL, -1);
    @(negedge clk);
    check_output("align_not_locked", 1024'(locked_o), 1024'(0));
    apply_stimulus(1'b0, V_TOTAL, -1);
    @(negedge clk);
    check_output("locked_after_f2", 1024'(locked_o), 1024'(1));
    apply_stimulus(1'b1, V_TOTAL, -1);
    @(negedge clk);
    check_output("first_pub_count", 1024'(pub_seen), 1024'(1));
    check_output("first_frame_cnt", 1024'(frame_cnt_o), 1024'(1));
    check_output("first_grid_red", 1024'(grid_o), 1024'(red_grid));

    stim_grid = blue_grid;
    apply_stimulus(1'b1, V_TOTAL, -1);
    stim_grid = pattern(5);
    apply_stimulus(1'b1, V_TOTAL, -1);
    @(negedge clk);
    check_output("cell_21_9", 1024'(grid_o[21][9]), 1024'(3'b001));
    check_output("blue_grid", 1024'(grid_o), 1024'(blue_grid));

    stim_grid = pattern(6);
    apply_stimulus(1'b1, V_TOTAL, 10);
    err_expected++;
    @(negedge clk);
    check_output("short_line_err", 1024'(err_seen), 1024'(err_expected));
    check_output("short_line_unlock", 1024'(locked_o), 1024'(0));
    check_output("short_line_grid", 1024'(grid_o), 1024'(last_pushed));
    check_output("short_line_pubs", 1024'(pub_seen), 1024'(pub_expected));
    stim_grid = pattern(7);
    apply_stimulus(1'b0, V_TOTAL, -1);
    @(negedge clk);
    check_output("relock_align", 1024'(locked_o), 1024'(0));
    stim_grid = pattern(8);
    apply_stimulus(1'b0, V_TOTAL, -1);
    stim_grid = pattern(9);
    apply_stimulus(1'b1, V_TOTAL, -1);
    @(negedge clk);
    check_output("relock_cnt", 1024'(frame_cnt_o), 1024'(exp_cnt));

    stim_grid = pattern(10);
    apply_stimulus(1'b1, V_TOTAL - 1, -1);
    stim_grid = pattern(11);
    apply_stimulus(1'b0, V_TOTAL, -1);
    err_expected++;
    @(negedge clk);
    check_output("short_frame_err", 1024'(err_seen), 1024'(err_expected));
    check_output("short_frame_unlock", 1024'(locked_o), 1024'(0));
    check_output("short_frame_cnt", 1024'(frame_cnt_o), 1024'(exp_cnt));
    check_output("short_frame_pubs", 1024'(pub_seen), 1024'(pub_expected));
    stim_grid = pattern(12);
    apply_stimulus(1'b0, V_TOTAL, -1);
    stim_grid = pattern(13);
    apply_stimulus(1'b0, V_TOTAL, -1);
    stim_grid = pattern(14);
    apply_stimulus(1'b1, V_TOTAL, -1);

    for (int k = 15; exp_cnt != 8'd0; k++) begin
      stim_grid = pattern(k);
      apply_stimulus(1'b1, V_TOTAL, -1);
    end
    @(negedge clk);
    check_output("wrap_cnt", 1024'(frame_cnt_o), 1024'(0));
    check_output("wrap_pubs", 1024'(pub_seen), 1024'(256));

    stim_grid = pattern(300);
    fork
      apply_stimulus(1'b1, V_TOTAL, -1);
      begin
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        exp_cnt = 8'd0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    join
    stim_grid = pattern(301);
    apply_stimulus(1'b0, V_TOTAL, -1);
    stim_grid = pattern(302);
    apply_stimulus(1'b0, V_TOTAL, -1);
    stim_grid = pattern(303);
    apply_stimulus(1'b1, V_TOTAL, -1);
    @(negedge clk);
    check_output("post_reset_cnt", 1024'(frame_cnt_o), 1024'(1));
    check_output("final_pubs", 1024'(pub_seen), 1024'(pub_expected));
    check_output("final_errs", 1024'(err_seen), 1024'(err_expected));
    check_output("queue_drained", 1024'(exp_q.size()), 1024'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
